// File: rtl/prog_launcher_pkg.sv
// Shared program codes, request bit positions and launcher state encoding.
// The register file uses the same program-code constants.
package prog_launcher_pkg;

    localparam int REQ_W = 5;

    localparam int REQ_FIB   = 0;
    localparam int REQ_SORT  = 1;
    localparam int REQ_SAVE  = 2;
    localparam int REQ_LOAD  = 3;
    localparam int REQ_PUSHA = 4;

    localparam logic [2:0] PROG_NONE  = 3'd0;
    localparam logic [2:0] PROG_FIB   = 3'd1;
    localparam logic [2:0] PROG_SORT  = 3'd2;
    localparam logic [2:0] PROG_SAVE  = 3'd3;
    localparam logic [2:0] PROG_LOAD  = 3'd4;
    localparam logic [2:0] PROG_PUSHA = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Lowest set bit wins; the code is the bit index plus one.
    function automatic logic [2:0] prio_code(input logic [REQ_W-1:0] rise);
        prio_code = PROG_NONE;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (rise[i]) prio_code = 3'(i + 1);
        end
    endfunction

endpackage

// File: rtl/prog_launcher.sv
// Turns button level requests into one fixed-length program-select pulse per
// press, plus launch status and a wrapping launch counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a rising request; selector is 0
// HOLD    | selector driven with the launched code for HOLD_CYCLES cycles
// RELEASE | selector is 0; waiting for every button to be up
module prog_launcher
    import prog_launcher_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int SEL_W       = 32,
    parameter int NUM_REQ     = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   program_selector,
    output logic               launch,
    output logic               active,
    output logic [2:0]         last_prog,
    output logic [7:0]         launch_count
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("prog_launcher: HOLD_CYCLES must be in 1..255");
        end
        if (NUM_REQ != REQ_W) begin : g_bad_req
            $error("prog_launcher: NUM_REQ must be 5");
        end
    endgenerate

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] rise;
    logic [2:0]         code;
    logic [7:0]         counter, counter_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               launch_nxt;
    logic               active_nxt;
    logic [2:0]         last_nxt;
    logic [7:0]         count_nxt;

    assign rise = req & ~req_q;
    assign code = prio_code(rise);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_RELEASE;
            req_q            <= '0;
            counter          <= '0;
            program_selector <= '0;
            launch           <= 1'b0;
            active           <= 1'b0;
            last_prog        <= PROG_NONE;
            launch_count     <= '0;
        end else begin
            state            <= state_nxt;
            req_q            <= req;
            counter          <= counter_nxt;
            program_selector <= sel_nxt;
            launch           <= launch_nxt;
            active           <= active_nxt;
            last_prog        <= last_nxt;
            launch_count     <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        sel_nxt     = program_selector;
        launch_nxt  = 1'b0;
        active_nxt  = active;
        last_nxt    = last_prog;
        count_nxt   = launch_count;
        case (state)
            ST_IDLE: begin
                sel_nxt    = '0;
                active_nxt = 1'b0;
                if (rise != '0) begin
                    sel_nxt     = SEL_W'(code);
                    launch_nxt  = 1'b1;
                    active_nxt  = 1'b1;
                    last_nxt    = code;
                    count_nxt   = launch_count + 8'd1;
                    counter_nxt = HOLD_LOAD;
                    state_nxt   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (counter == 8'd0) begin
                    sel_nxt    = '0;
                    active_nxt = 1'b0;
                    state_nxt  = ST_RELEASE;
                end else begin
                    counter_nxt = counter - 8'd1;
                end
            end
            ST_RELEASE: begin
                sel_nxt    = '0;
                active_nxt = 1'b0;
                if (req == '0) state_nxt = ST_IDLE;
            end
            default: begin
                sel_nxt    = '0;
                active_nxt = 1'b0;
                state_nxt  = ST_RELEASE;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: default 16-cycle hold build plus a
// 1-cycle hold build exercised through a full launch-counter wrap.
module tb_prog_launcher;
    import prog_launcher_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n, reset1_n;
    logic [4:0]  req, req1;
    logic [31:0] sel, sel1;
    logic        launch, launch1, active, active1;
    logic [2:0]  last_prog, last_prog1;
    logic [7:0]  launch_count, launch_count1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    prog_launcher #(.HOLD_CYCLES(16), .SEL_W(32), .NUM_REQ(5)) dut (
        .clock(clock), .reset_n(reset_n), .req(req),
        .program_selector(sel), .launch(launch), .active(active),
        .last_prog(last_prog), .launch_count(launch_count)
    );

    prog_launcher #(.HOLD_CYCLES(1), .SEL_W(32), .NUM_REQ(5)) dut1 (
        .clock(clock), .reset_n(reset1_n), .req(req1),
        .program_selector(sel1), .launch(launch1), .active(active1),
        .last_prog(last_prog1), .launch_count(launch_count1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the launch cycle; follows the pulse to its end, counting
    // cycles at the expected code and cycles at any other nonzero value.
    task automatic measure(input logic [31:0] code, output int len, output int bad, output int extra);
        len = 0; bad = 0; extra = 0;
        for (int i = 0; i < 300; i++) begin
            if (sel == 32'd0) break;
            if (sel == code) len++; else bad++;
            if (i > 0 && launch) extra++;
            tick();
        end
        if (sel != 32'd0) bad++;
    endtask

    int len, bad, extra, n;

    initial begin
        reset_n = 1'b0; reset1_n = 1'b0;
        req = '0; req1 = '0;
        tick(); tick(); tick();
        check("rst_sel", sel, 0);
        check("rst_launch", 32'(launch), 0);
        check("rst_active", 32'(active), 0);
        check("rst_last", 32'(last_prog), 0);
        check("rst_count", 32'(launch_count), 0);

        // First launch: fib, held for 100 cycles in total
        reset_n = 1'b1;
        tick();
        req = 5'b00001;
        tick();
        check("fib_sel", sel, 1);
        check("fib_launch", 32'(launch), 1);
        check("fib_active", 32'(active), 1);
        check("fib_last", 32'(last_prog), 1);
        check("fib_count", 32'(launch_count), 1);
        measure(32'd1, len, bad, extra);
        check("fib_len", 32'(len), 16);
        check("fib_bad", 32'(bad), 0);
        check("fib_extra", 32'(extra), 0);
        check("fib_inactive", 32'(active), 0);
        n = 0;
        for (int i = 0; i < 83; i++) begin
            tick();
            if (launch || sel != 32'd0) n++;
        end
        check("fib_held_nolaunch", 32'(n), 0);
        check("fib_held_count", 32'(launch_count), 1);

        // Release and press again
        req = '0; tick();
        req = 5'b00001; tick();
        check("fib2_count", 32'(launch_count), 2);
        measure(32'd1, len, bad, extra);
        check("fib2_len", 32'(len), 16);
        req = '0; tick();

        // Simultaneous rises: sort wins over save and pusha
        req = 5'b10110; tick();
        check("multi_sel", sel, 2);
        check("multi_last", 32'(last_prog), 2);
        check("multi_count", 32'(launch_count), 3);
        measure(32'd2, len, bad, extra);
        check("multi_len", 32'(len), 16);
        check("multi_bad", 32'(bad), 0);
        req = '0; tick();

        // Press save, then load rises during HOLD and must be ignored
        req = 5'b00100; tick();
        check("save_sel", sel, 3);
        tick(); tick();
        req = 5'b01100;
        measure(32'd3, len, bad, extra);
        check("save_len", 32'(len), 14);
        check("save_bad", 32'(bad), 0);
        check("save_extra", 32'(extra), 0);
        check("save_last", 32'(last_prog), 3);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (launch || sel != 32'd0) n++;
        end
        req = 5'b01000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (launch || sel != 32'd0) n++;
        end
        check("load_ignored", 32'(n), 0);
        check("load_ignored_count", 32'(launch_count), 4);
        req = '0; tick();
        req = 5'b01000; tick();
        check("load_sel", sel, 4);
        check("load_count", 32'(launch_count), 5);
        measure(32'd4, len, bad, extra);
        check("load_len", 32'(len), 16);
        req = '0; tick();

        // Reset pulse mid-HOLD with sort held down
        req = 5'b00010; tick();
        check("sort_sel", sel, 2);
        check("sort_count", 32'(launch_count), 6);
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        check("async_sel", sel, 0);
        check("async_active", 32'(active), 0);
        check("async_count", 32'(launch_count), 0);
        tick();
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (launch || sel != 32'd0) n++;
        end
        check("post_rst_nolaunch", 32'(n), 0);
        check("post_rst_last", 32'(last_prog), 0);
        req = '0; tick();
        req = 5'b00010; tick();
        check("repress_sel", sel, 2);
        check("repress_count", 32'(launch_count), 1);
        check("repress_last", 32'(last_prog), 2);
        req = '0;

        // HOLD_CYCLES = 1 build through a launch-counter wrap
        reset1_n = 1'b1;
        tick();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 255 && launch_count1 != 8'd255) bad++;
            req1 = 5'b00001; tick();
            if (sel1 != 32'd1 || !launch1) bad++;
            req1 = '0; tick();
            if (sel1 != 32'd0) bad++;
            tick();
        end
        check("h1_pulse_errs", 32'(bad), 0);
        check("h1_wrap_count", 32'(launch_count1), 0);
        check("h1_last", 32'(last_prog1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
